menu_button_ctl: RTL and testbench

- Sequences the on-screen text-button menu.
- Hit-tests the mouse against three vertically stacked button rectangles and debounces the left mouse button.
- Commits a selection only on press-and-release over the same button.
- Drives the frame-aligned display_buttons/help_screen/game_active levels that gate the text-box overlay stages and the game datapath.
- Sits between the mouse controller and the drawing pipeline, in the 65 MHz pixel-clock domain.

---
 rtl/menu_pkg.sv | 25 ++
 rtl/menu_button_ctl_debounce.sv | 48 ++++
 rtl/menu_button_ctl.sv | 166 ++++++++++++++++
 tb/tb_menu_button_ctl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types and constants for the text-button menu controller.
package menu_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_ARMED = 3'd1,
        ST_HELP  = 3'd2,
        ST_GAME  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [1:0] BTN_START = 2'd0;
    localparam logic [1:0] BTN_HELP  = 2'd1;
    localparam logic [1:0] BTN_EXIT  = 2'd2;

    localparam int NUM_BTN       = 3;
    localparam int HIT_MARGIN_LO = 10;
    localparam int HIT_MARGIN_HI = 5;

    function automatic logic in_range(input logic [11:0] v, input logic [11:0] lo,
                                      input logic [11:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/menu_button_ctl_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for the raw mouse button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, done;

    assign differ = (sync2_q != level_q);
    assign done   = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (differ && !done) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= done ? sync2_q : level_q;
            rise_q  <= done & sync2_q;
            fall_q  <= done & ~sync2_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/menu_button_ctl.sv
// Menu sequencer: hit-tests the mouse against three stacked buttons, commits on
// press-and-release over the same button, and frame-aligns the overlay/game enables.
//   state  | meaning
//   MENU   | buttons shown, waiting for a press over a button
//   ARMED  | pressed over arm_idx, waiting for release
//   HELP   | help page, any click returns to MENU
//   GAME   | game running until game_over
//   HALT   | exit requested, terminal until rst
module menu_button_ctl
    import menu_pkg::*;
#(
    parameter int BTN_X_POS       = 432,
    parameter int BTN_Y_POS       = 160,
    parameter int BTN_Y_STEP      = 120,
    parameter int BTN_X_SIZE      = 128,
    parameter int BTN_Y_SIZE      = 80,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos_i,
    input  logic [11:0] mouse_ypos_i,
    input  logic        mouse_left_i,
    input  logic        vsync_in_i,
    input  logic        game_over_i,
    output logic        hover_valid_o,
    output logic [1:0]  hover_idx_o,
    output logic        select_pulse_o,
    output logic [1:0]  select_idx_o,
    output logic        display_buttons_o,
    output logic        help_screen_o,
    output logic        game_active_o,
    output logic        exit_req_o
);
    localparam logic [11:0] X_LO = 12'(BTN_X_POS - HIT_MARGIN_LO);
    localparam logic [11:0] X_HI = 12'(BTN_X_POS + BTN_X_SIZE - HIT_MARGIN_HI);

    state_e     state_q, state_d;
    logic [1:0] arm_idx_q, arm_idx_d;
    logic       help_seen_q, help_seen_d;
    logic       hover_valid_q, hover_valid_d;
    logic [1:0] hover_idx_q, hover_idx_d;
    logic       select_pulse_q;
    logic [1:0] select_idx_q;
    logic       vsync_d_q, disp_q, help_q, game_q;
    logic       btn_level, btn_rise, btn_fall;
    logic       hit_any;
    logic [1:0] hit_idx;
    logic       menu_like, commit, disp_req, help_req, game_req, exit_req;
    logic       vs_edge;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .raw_in_i (mouse_left_i),
        .level_o  (btn_level),
        .rise_o   (btn_rise),
        .fall_o   (btn_fall)
    );

    // Descending scan so the lowest overlapping index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 2'd0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (in_range(mouse_xpos_i, X_LO, X_HI) &&
                in_range(mouse_ypos_i, 12'(BTN_Y_POS + k * BTN_Y_STEP - HIT_MARGIN_LO),
                         12'(BTN_Y_POS + k * BTN_Y_STEP + BTN_Y_SIZE))) begin
                hit_any = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    assign menu_like     = (state_q == ST_MENU) || (state_q == ST_ARMED);
    assign hover_valid_d = hit_any && menu_like;
    assign hover_idx_d   = hover_valid_d ? hit_idx : hover_idx_q;
    assign vs_edge       = vsync_in_i & ~vsync_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MENU;
            arm_idx_q   <= 2'd0;
            help_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_idx_q   <= arm_idx_d;
            help_seen_q <= help_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        arm_idx_d   = arm_idx_q;
        help_seen_d = 1'b0;
        case (state_q)
            ST_MENU: begin
                if (btn_rise && hover_valid_q) begin
                    arm_idx_d = hover_idx_q;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (btn_fall) begin
                    if (!commit)                    state_d = ST_MENU;
                    else if (arm_idx_q == BTN_START) state_d = ST_GAME;
                    else if (arm_idx_q == BTN_HELP)  state_d = ST_HELP;
                    else                             state_d = ST_HALT;
                end
            end
            ST_HELP: begin
                // Only a button seen down inside HELP may dismiss the page.
                help_seen_d = help_seen_q | btn_level;
                if (btn_fall && help_seen_q) begin
                    state_d     = ST_MENU;
                    help_seen_d = 1'b0;
                end
            end
            ST_GAME: if (game_over_i) state_d = ST_MENU;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_MENU;
        endcase
    end

    always_comb begin
        commit   = (state_q == ST_ARMED) && btn_fall && hover_valid_q &&
                   (hover_idx_q == arm_idx_q);
        disp_req = menu_like;
        help_req = (state_q == ST_HELP);
        game_req = (state_q == ST_GAME);
        exit_req = (state_q == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hover_valid_q  <= 1'b0;
            hover_idx_q    <= 2'd0;
            select_pulse_q <= 1'b0;
            select_idx_q   <= 2'd0;
            vsync_d_q      <= 1'b0;
            disp_q         <= 1'b0;
            help_q         <= 1'b0;
            game_q         <= 1'b0;
        end else begin
            hover_valid_q  <= hover_valid_d;
            hover_idx_q    <= hover_idx_d;
            select_pulse_q <= commit;
            select_idx_q   <= commit ? arm_idx_q : select_idx_q;
            vsync_d_q      <= vsync_in_i;
            if (vs_edge) begin
                disp_q <= disp_req;
                help_q <= help_req;
                game_q <= game_req;
            end
        end
    end

    assign hover_valid_o     = hover_valid_q;
    assign hover_idx_o       = hover_idx_q;
    assign select_pulse_o    = select_pulse_q;
    assign select_idx_o      = select_idx_q;
    assign display_buttons_o = disp_q;
    assign help_screen_o     = help_q;
    assign game_active_o     = game_q;
    assign exit_req_o        = exit_req;
endmodule

// File: tb/tb_menu_button_ctl.sv
// Bench for menu_button_ctl: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the menu rules.
module tb_menu_button_ctl;
    localparam int DEB = 4;
    localparam int M_MENU = 10, M_ARMED = 11, M_HELP = 12, M_GAME = 13, M_HALT = 14;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] mx = '0, my = '0;
    logic        ml = 1'b0, vs = 1'b0, go = 1'b0;
    logic        hv, sp, disp, helps, game, exitr;
    logic [1:0]  hi, si;

    int total = 0, bad = 0, pulse_cnt = 0;

    int m_mode = M_MENU, m_hi = 0, m_sel = 0, m_arm = 0, m_run = 0;
    bit m_hv, m_pulse, m_disp, m_help, m_game, m_vsd, m_r1, m_r2, m_lvl;
    bit m_press, m_rel, m_hpress;

    always #5 clk = ~clk;

    menu_button_ctl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .mouse_xpos_i(mx), .mouse_ypos_i(my), .mouse_left_i(ml),
        .vsync_in_i(vs), .game_over_i(go),
        .hover_valid_o(hv), .hover_idx_o(hi),
        .select_pulse_o(sp), .select_idx_o(si),
        .display_buttons_o(disp), .help_screen_o(helps),
        .game_active_o(game), .exit_req_o(exitr)
    );

    function automatic int hit_of(input int x, input int y);
        int top;
        for (int k = 0; k < 3; k++) begin
            top = 160 + 120 * k;
            if (x >= 422 && x <= 555 && y >= top - 10 && y <= top + 80) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit menu_like, synced;
        int h;
        if (rst) begin
            m_mode = M_MENU; m_hv = 0; m_hi = 0; m_pulse = 0; m_sel = 0; m_arm = 0;
            m_disp = 0; m_help = 0; m_game = 0; m_vsd = 0;
            m_r1 = 0; m_r2 = 0; m_lvl = 0; m_run = 0; m_press = 0; m_rel = 0; m_hpress = 0;
            return;
        end
        menu_like = (m_mode == M_MENU) || (m_mode == M_ARMED);
        if (vs && !m_vsd) begin
            m_disp = menu_like;
            m_help = (m_mode == M_HELP);
            m_game = (m_mode == M_GAME);
        end
        m_vsd = vs;
        m_pulse = 0;
        case (m_mode)
            M_MENU: if (m_press && m_hv) begin m_arm = m_hi; m_mode = M_ARMED; end
            M_ARMED: if (m_rel) begin
                if (m_hv && m_hi == m_arm) begin
                    m_pulse = 1; m_sel = m_arm; m_hpress = 0;
                    m_mode = (m_arm == 0) ? M_GAME : (m_arm == 1) ? M_HELP : M_HALT;
                end else m_mode = M_MENU;
            end
            M_HELP: if (m_press) m_hpress = 1;
                    else if (m_rel && m_hpress) begin m_mode = M_MENU; m_hpress = 0; end
            M_GAME: if (go) m_mode = M_MENU;
            default: ;
        endcase
        h = hit_of(int'(mx), int'(my));
        m_hv = menu_like && (h >= 0);
        if (m_hv) m_hi = h;
        // raw button seen two edges late, then must disagree DEB edges in a row
        synced = m_r2; m_r2 = m_r1; m_r1 = ml;
        m_press = 0; m_rel = 0;
        if (synced != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
                m_lvl = synced; m_press = synced; m_rel = !synced; m_run = 0;
            end
        end else m_run = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (sp === 1'b1) pulse_cnt++;
        chk("hover_valid", 32'(hv), 32'(m_hv));
        chk("hover_idx", 32'(hi), 32'(m_hi));
        chk("select_pulse", 32'(sp), 32'(m_pulse));
        chk("select_idx", 32'(si), 32'(m_sel));
        chk("display_buttons", 32'(disp), 32'(m_disp));
        chk("help_screen", 32'(helps), 32'(m_help));
        chk("game_active", 32'(game), 32'(m_game));
        chk("exit_req", 32'(exitr), 32'(m_mode == M_HALT));
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_edge();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    task automatic click();
        ml = 1'b1; ticks(8);
        ml = 1'b0; ticks(8);
    endtask

    task automatic move(input int x, input int y);
        mx = 12'(x); my = 12'(y); ticks(2);
    endtask

    initial begin
        int hold, vcnt, mcnt;
        @(negedge clk);
        ticks(3);
        rst = 1'b0; tick();
        chk("rst_display", 32'(disp), 0);
        chk("rst_hover", 32'(hv), 0);
        chk("rst_pulse", 32'(sp), 0);
        chk("rst_exit", 32'(exitr), 0);
        vs = 1'b1; tick();
        chk("first_vs_display", 32'(disp), 1);
        chk("first_vs_game", 32'(game), 0);
        vs = 1'b0; tick();

        // HELP commit and dismissal
        move(432, 300);
        chk("help_hover_valid", 32'(hv), 1);
        chk("help_hover_idx", 32'(hi), 1);
        pulse_cnt = 0; click();
        chk("help_pulses", 32'(pulse_cnt), 1);
        chk("help_sel", 32'(si), 1);
        vs_edge();
        chk("help_screen_on", 32'(helps), 1);
        chk("help_disp_off", 32'(disp), 0);
        click(); vs_edge();
        chk("help_back_disp", 32'(disp), 1);
        chk("help_back_help", 32'(helps), 0);

        // press on corner, slide off, release: cancelled
        move(422, 150);
        chk("corner_hover", 32'(hv), 1);
        pulse_cnt = 0;
        ml = 1'b1; ticks(8);
        move(600, 150);
        chk("off_hover", 32'(hv), 0);
        ml = 1'b0; ticks(8);
        vs_edge();
        chk("cancel_pulses", 32'(pulse_cnt), 0);
        chk("cancel_disp", 32'(disp), 1);

        // hit box boundaries
        move(555, 240);
        chk("edge_hit_valid", 32'(hv), 1);
        chk("edge_hit_idx", 32'(hi), 0);
        move(556, 240);
        chk("edge_x_miss", 32'(hv), 0);
        move(432, 241);
        chk("edge_y_miss", 32'(hv), 0);

        // START, game over, then a short glitch must not click
        move(500, 200); pulse_cnt = 0; click();
        chk("start_sel", 32'(si), 0);
        vs_edge();
        chk("game_on", 32'(game), 1);
        chk("game_disp_off", 32'(disp), 0);
        chk("game_hover_off", 32'(hv), 0);
        go = 1'b1; tick(); go = 1'b0; tick();
        vs_edge();
        chk("gameover_disp", 32'(disp), 1);
        chk("gameover_game", 32'(game), 0);
        pulse_cnt = 0;
        ml = 1'b1; ticks(3); ml = 1'b0; ticks(12);
        vs_edge();
        chk("glitch_pulses", 32'(pulse_cnt), 0);
        chk("glitch_game", 32'(game), 0);

        // EXIT is terminal until reset
        move(432, 400); pulse_cnt = 0; click();
        chk("exit_sel", 32'(si), 2);
        chk("exit_req", 32'(exitr), 1);
        vs_edge();
        chk("halt_disp", 32'(disp), 0);
        chk("halt_help", 32'(helps), 0);
        chk("halt_game", 32'(game), 0);
        move(432, 300); click();
        chk("halt_pulses", 32'(pulse_cnt), 1);
        chk("halt_sticky", 32'(exitr), 1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("rst_clears_exit", 32'(exitr), 0);

        // reset while ARMED issues no pulse
        move(432, 300); pulse_cnt = 0;
        ml = 1'b1; ticks(8);
        rst = 1'b1; tick(); rst = 1'b0; ml = 1'b0; ticks(10);
        chk("armed_rst_pulses", 32'(pulse_cnt), 0);

        hold = 0; vcnt = 0; mcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin ml = ~ml; hold = $urandom_range(1, 14); end else hold--;
            if (vcnt == 0) begin vs = ~vs; vcnt = $urandom_range(2, 15); end else vcnt--;
            if (mcnt == 0) begin
                mx = 12'($urandom_range(410, 570));
                my = 12'($urandom_range(135, 495));
                mcnt = $urandom_range(3, 40);
            end else mcnt--;
            go  = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
